// File: rtl/ad_div_pkg.sv
// Shared definitions for the sequential signed divider (ad_div_seq).
package ad_div_pkg;

    // Default operand/result width.
    localparam int unsigned AD_DIV_N = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } ad_div_state_e;

    // Step-counter width: clog2(n), never narrower than one bit.
    function automatic int unsigned ad_div_cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Step-counter width for the default build.
    localparam int unsigned AD_DIV_CNT_W = ad_div_cnt_w(AD_DIV_N);

endpackage : ad_div_pkg

// File: rtl/ad_div_seq_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface ad_div_seq_if
    import ad_div_pkg::*;
#(
    parameter int unsigned N = AD_DIV_N
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         ovf;
    logic         dz;

    // Requester side (operation decoder / testbench).
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dz
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dz
    );
endinterface : ad_div_seq_if

// File: rtl/ad_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference if non-negative, else restore.
module ad_div_step
    import ad_div_pkg::*;
#(
    parameter int unsigned N = AD_DIV_N
) (
    input  logic [N:0]   i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_div,
    output logic [N:0]   o_rem_c,
    output logic         o_q_c
);
    logic [N+1:0] w_shift;
    logic [N+1:0] w_diff;

    // Shift and trial subtract; the extra top bit acts as the sign of the trial.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_div};
    assign o_q_c   = ~w_diff[N+1];
    assign o_rem_c = o_q_c ? w_diff[N:0] : w_shift[N:0];

endmodule : ad_div_step

// File: rtl/ad_div_seq.sv
// Sequential signed divider: magnitudes in, N restoring steps, sign fix-up,
// truncated quotient and remainder (remainder follows the dividend's sign).
// Optional feature macro: AD_DIV_ZERO_DETECT_EN (early divide-by-zero result).
module ad_div_seq
    import ad_div_pkg::*;
#(
    parameter int unsigned N = AD_DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    ad_div_seq_if.slave  bus
);
    localparam int unsigned CNT_W   = ad_div_cnt_w(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    ad_div_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N:0]       r_rem;
    logic [N-1:0]     r_dvd;
    logic [N-1:0]     r_dsr;
    logic             r_sa;
    logic             r_sq;
    logic             r_ovf_pend;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_rmd;
    logic             r_ovf;
`ifdef AD_DIV_ZERO_DETECT_EN
    logic             r_zero;
    logic             r_dz;
`endif

    logic [N-1:0]     w_abs_a;
    logic [N-1:0]     w_abs_b;
    logic [N:0]       w_rem_nxt;
    logic             w_qbit;

    // Operand magnitudes; |-2^(N-1)| wraps to 2^(N-1), which is valid unsigned.
    assign w_abs_a = bus.dividend[N-1] ? (N'(0) - bus.dividend) : bus.dividend;
    assign w_abs_b = bus.divisor[N-1]  ? (N'(0) - bus.divisor)  : bus.divisor;

    // Single shared restoring step, fed from the top of the dividend register.
    ad_div_step #(.N(N)) u_step (
        .i_rem   (r_rem),
        .i_bit   (r_dvd[N-1]),
        .i_div   (r_dsr),
        .o_rem_c (w_rem_nxt),
        .o_q_c   (w_qbit)
    );

    // Controller FSM and datapath; quotient bits shift into the dividend register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_sa       <= 1'b0;
            r_sq       <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quo      <= '0;
            r_rmd      <= '0;
            r_ovf      <= 1'b0;
`ifdef AD_DIV_ZERO_DETECT_EN
            r_zero     <= 1'b0;
            r_dz       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sa       <= bus.dividend[N-1];
                        r_sq       <= bus.dividend[N-1] ^ bus.divisor[N-1];
                        r_dvd      <= w_abs_a;
                        r_dsr      <= w_abs_b;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (bus.dividend == MIN_NEG) && (bus.divisor == '1);
                        r_busy     <= 1'b1;
`ifdef AD_DIV_ZERO_DETECT_EN
                        // A zero divisor skips the steps; FIX emits the flagged result.
                        r_zero     <= (bus.divisor == '0);
                        r_state    <= (bus.divisor == '0) ? ST_FIX : ST_DIV;
`else
                        r_state    <= ST_DIV;
`endif
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[N-2:0], w_qbit};
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
`ifdef AD_DIV_ZERO_DETECT_EN
                    if (r_zero) begin
                        // r_dvd still holds |dividend|; re-sign it to return the dividend.
                        r_quo <= '1;
                        r_rmd <= r_sa ? (N'(0) - r_dvd) : r_dvd;
                        r_ovf <= 1'b0;
                        r_dz  <= 1'b1;
                    end else begin
                        r_quo <= r_sq ? (N'(0) - r_dvd) : r_dvd;
                        r_rmd <= r_sa ? (N'(0) - r_rem[N-1:0]) : r_rem[N-1:0];
                        r_ovf <= r_ovf_pend;
                        r_dz  <= 1'b0;
                    end
`else
                    r_quo <= r_sq ? (N'(0) - r_dvd) : r_dvd;
                    r_rmd <= r_sa ? (N'(0) - r_rem[N-1:0]) : r_rem[N-1:0];
                    r_ovf <= r_ovf_pend;
`endif
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rmd;
    assign bus.ovf       = r_ovf;
`ifdef AD_DIV_ZERO_DETECT_EN
    assign bus.dz        = r_dz;
`else
    assign bus.dz        = 1'b0;
`endif

endmodule : ad_div_seq

// File: tb/tb_ad_div_seq.sv
// Directed bench for ad_div_seq (N=8) with hand-computed expected results.
module tb_ad_div_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    ad_div_seq_if #(.N(8)) bus ();

    ad_div_seq #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one division; optionally poke start during DIV and during DONE.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic eovf, input logic edz, input int elat, input bit poke);
        int  lat;
        bit  got;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        check_eq({tag, " busy_rise"}, 32'(bus.busy), 32'd1);
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = 8'h03;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 2) begin
                bus.start    = 1'b1;
                bus.dividend = 8'h11;
                bus.divisor  = 8'h01;
            end
            if (poke && k == 3) bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                lat = k;
                check_eq({tag, " quotient"},  32'(bus.quotient),  32'(eq));
                check_eq({tag, " remainder"}, 32'(bus.remainder), 32'(er));
                check_eq({tag, " ovf"},       32'(bus.ovf),       32'(eovf));
                check_eq({tag, " dz"},        32'(bus.dz),        32'(edz));
                if (poke) begin
                    bus.start    = 1'b1;
                    bus.dividend = 8'h22;
                    bus.divisor  = 8'h02;
                end
                break;
            end
        end
        if (!got) $display("FAIL %s done_timeout: got no done, expected done", tag);
        if (!got) n_mis++;
        check_eq({tag, " latency"}, 32'(lat), 32'(elat));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, " busy_fall"},  32'(bus.busy), 32'd0);
        if (poke) begin
            int extra;
            extra = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1;
                if (bus.done || bus.busy) extra++;
            end
            check_eq({tag, " no_requeue"},  32'(extra),        32'd0);
            check_eq({tag, " held_quot"},   32'(bus.quotient), 32'(eq));
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_mis        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy",      32'(bus.busy),      32'd0);
        check_eq("reset done",      32'(bus.done),      32'd0);
        check_eq("reset quotient",  32'(bus.quotient),  32'd0);
        check_eq("reset remainder", 32'(bus.remainder), 32'd0);
        check_eq("reset ovf",       32'(bus.ovf),       32'd0);
        check_eq("reset dz",        32'(bus.dz),        32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("100/7",    8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9, 1'b0);
        run_div("-100/7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 9, 1'b0);
        run_div("100/-7",   8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9, 1'b0);
        run_div("-128/1",   8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 9, 1'b0);
        run_div("-7/2",     8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0, 1'b0, 9, 1'b0);
        run_div("127/-128", 8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 9, 1'b0);
        run_div("-128/-128",8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 9, 1'b0);
`ifdef AD_DIV_ZERO_DETECT_EN
        run_div("5/0",      8'h05,  8'h00,  8'hFF, 8'h05, 1'b0, 1'b1, 1, 1'b0);
        run_div("-5/0",     8'hFB,  8'h00,  8'hFF, 8'hFB, 1'b0, 1'b1, 1, 1'b0);
`else
        run_div("5/0",      8'h05,  8'h00,  8'hFF, 8'h05, 1'b0, 1'b0, 9, 1'b0);
        run_div("-5/0",     8'hFB,  8'h00,  8'h01, 8'hFB, 1'b0, 1'b0, 9, 1'b0);
`endif
        run_div("ignore",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9, 1'b1);
        run_div("-128/-1",  8'h80,  8'hFF,  8'h80, 8'h00, 1'b1, 1'b0, 9, 1'b0);

        // Reset in the middle of a division clears everything immediately.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst busy",      32'(bus.busy),      32'd0);
        check_eq("midrst done",      32'(bus.done),      32'd0);
        check_eq("midrst quotient",  32'(bus.quotient),  32'd0);
        check_eq("midrst remainder", 32'(bus.remainder), 32'd0);
        check_eq("midrst ovf",       32'(bus.ovf),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("post_rst", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_ad_div_seq
